// File: rtl/matmul_arbiter.sv
// Round-robin arbiter that shares one matmul_array engine between NUM_REQ requesters.
// Each grant runs one engine operation, guarded by a watchdog that forces release on a hung engine.
module matmul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       mm_start,
    input  logic                       mm_done,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       clr_err
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        RELEASE
    } state_t;

    state_t             state, state_d;
    logic [SEL_W-1:0]   ptr, ptr_d;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_d;
    logic [NUM_REQ-1:0] gnt_d, req_done_d;
    logic [SEL_W-1:0]   sel_d;
    logic               mm_start_d, busy_d, timeout_err_d;

    logic               rr_found;
    logic [SEL_W-1:0]   rr_win;
    logic [SEL_W-1:0]   rr_idx;

    // Search upward from ptr with wrap-around; the first pending request wins.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = SEL_W'((int'(ptr) + i) % NUM_REQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        wd_cnt_d      = wd_cnt;
        gnt_d         = gnt;
        sel_d         = sel;
        mm_start_d    = 1'b0;
        req_done_d    = '0;
        busy_d        = busy;
        timeout_err_d = clr_err ? 1'b0 : timeout_err;

        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_d       = GRANT;
                    gnt_d         = '0;
                    gnt_d[rr_win] = 1'b1;
                    sel_d         = rr_win;
                    mm_start_d    = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            GRANT: begin
                state_d  = WAIT;
                wd_cnt_d = '0;
            end
            WAIT: begin
                if (mm_done || wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_d    = RELEASE;
                    gnt_d      = '0;
                    req_done_d = gnt;
                    ptr_d      = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
                    // A new timeout overrides a simultaneous clear.
                    if (!mm_done) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wd_cnt      <= '0;
            gnt         <= '0;
            sel         <= '0;
            mm_start    <= 1'b0;
            req_done    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            wd_cnt      <= wd_cnt_d;
            gnt         <= gnt_d;
            sel         <= sel_d;
            mm_start    <= mm_start_d;
            req_done    <= req_done_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of owner, wait count, pointer and error flag.
module tb_matmul_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         gnt;
    logic [$clog2(N)-1:0] sel;
    logic                 mm_start;
    logic                 mm_done = 1'b0;
    logic [N-1:0]         req_done;
    logic                 busy;
    logic                 timeout_err;
    logic                 clr_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int eng_lat = 1;
    int eng_cnt = 0;
    bit auto_drop = 1'b1;

    matmul_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel),
        .mm_start(mm_start), .mm_done(mm_done), .req_done(req_done),
        .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; requesters and the engine react to outputs seen here.
    task automatic applyStimulus(input logic inject, input logic clear, input logic rst_v);
        @(negedge clk);
        if (auto_drop) req = req & ~req_done;
        mm_done = 1'b0;
        if (!rst_v) eng_cnt = 0;
        else if (mm_start) eng_cnt = eng_lat;
        else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) mm_done = 1'b1;
        end
        mm_done = mm_done | inject;
        clr_err = clear;
        rst_n   = rst_v;
    endtask

    task automatic doReset();
        req = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    // Runs until one req_done is seen; cycle numbers count falling edges since the call.
    task automatic runOp(input logic clear, output int grant_idx, output int start_cyc,
                         output int done_cyc, output int busy_cyc, output logic [N-1:0] done_vec);
        grant_idx = -1; start_cyc = -1; done_cyc = -1; busy_cyc = 0; done_vec = '0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            applyStimulus(1'b0, clear, 1'b1);
            if (busy) busy_cyc++;
            if (mm_start && start_cyc < 0) begin
                start_cyc = c;
                grant_idx = int'(sel);
            end
            if (req_done != '0) begin
                done_cyc = c;
                done_vec = req_done;
            end
        end
        if (done_cyc < 0) checkOutput("op_budget", 32'd0, 32'd1);
    endtask

    // Reference model: who owns the engine, how long it has waited, and where the search pointer sits.
    int           m_owner = -1;
    int           m_wait = 0;
    int           m_ptr = 0;
    int           m_sel = 0;
    bit           m_granting = 1'b0;
    bit           m_releasing = 1'b0;
    bit           m_err = 1'b0;
    bit           m_start;
    bit           m_busy;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_done;

    always @(posedge clk) begin
        m_start = 1'b0;
        m_done  = '0;
        if (!rst_n) begin
            m_owner = -1; m_wait = 0; m_ptr = 0; m_sel = 0;
            m_granting = 1'b0; m_releasing = 1'b0; m_err = 1'b0;
        end else begin
            if (clr_err) m_err = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && ((req >> ((m_ptr + k) % N)) & 1) != 0) m_owner = (m_ptr + k) % N;
                end
                if (m_owner >= 0) begin
                    m_sel = m_owner; m_start = 1'b1; m_granting = 1'b1;
                end
            end else if (m_releasing) begin
                m_owner = -1; m_releasing = 1'b0;
            end else if (m_granting) begin
                m_granting = 1'b0; m_wait = 0;
            end else if (mm_done || m_wait == TMO - 1) begin
                if (!mm_done) m_err = 1'b1;
                m_done = N'(1) << m_owner;
                m_ptr = (m_owner + 1) % N;
                m_releasing = 1'b1;
            end else begin
                m_wait++;
            end
        end
        m_gnt  = (m_owner >= 0 && !m_releasing) ? (N'(1) << m_owner) : '0;
        m_busy = (m_owner >= 0);
        #1;
        checkOutput("gnt", 32'(gnt), 32'(m_gnt));
        checkOutput("sel", 32'(sel), 32'(m_sel));
        checkOutput("mm_start", 32'(mm_start), 32'(m_start));
        checkOutput("req_done", 32'(req_done), 32'(m_done));
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
    end

    int           g, s, d, b;
    logic [N-1:0] dv;

    initial begin
        $display("[TB] starting matmul_arbiter bench");
        doReset();

        // Single requester, engine completes in the 6th WAIT cycle.
        eng_lat = 6;
        req = 4'b0001;
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t1_grant", 32'(g), 32'd0);
        checkOutput("t1_start_lat", 32'(s), 32'd1);
        checkOutput("t1_done_cyc", 32'(d), 32'(eng_lat + 2));
        checkOutput("t1_busy_cycles", 32'(b), 32'd8);
        checkOutput("t1_done_vec", 32'(dv), 32'h1);

        // All requesters held; each is served once in ascending order, starts 4 cycles apart.
        doReset();
        eng_lat = 1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            runOp(1'b0, g, s, d, b, dv);
            checkOutput("t2_grant", 32'(g), 32'(i));
            checkOutput("t2_done_vec", 32'(dv), 32'(N'(1) << i));
            if (i > 0) checkOutput("t2_start_spacing", 32'(s + 2), 32'd4);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Pointer wrap: after serving 2, requesters 0 and 2 pending -> 0 wins.
        doReset();
        req = 4'b0100;
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t3_first_grant", 32'(g), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        req = 4'b0101;
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t3_wrap_grant", 32'(g), 32'd0);
        req = '0;

        // Watchdog: engine never answers.
        doReset();
        eng_lat = -1;
        req = 4'b0001;
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t4_release_cyc", 32'(d), 32'(TMO + 2));
        checkOutput("t4_done_vec", 32'(dv), 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("t4_err_sticky", 32'(timeout_err), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_err_cleared", 32'(timeout_err), 32'd0);
        req = 4'b0001;
        runOp(1'b1, g, s, d, b, dv);
        checkOutput("t4_set_beats_clear", 32'(timeout_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Stray mm_done in IDLE and in GRANT is ignored.
        doReset();
        eng_lat = 3;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        end
        req = 4'b0001;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t5_in_grant", 32'(mm_start), 32'd1);
        d = -1;
        for (int c = 2; c <= 30 && d < 0; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (req_done != '0) d = c;
        end
        checkOutput("t5_done_cyc", 32'(d), 32'(eng_lat + 2));

        // Reset in WAIT abandons the operation; pointer restarts at 0.
        doReset();
        eng_lat = 1;
        req = 4'b0100;
        runOp(1'b0, g, s, d, b, dv);
        applyStimulus(1'b0, 1'b0, 1'b1);
        eng_lat = -1;
        req = 4'b1000;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t6_in_wait", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t6_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("t6_rst_sel", 32'(sel), 32'd0);
        checkOutput("t6_rst_start", 32'(mm_start), 32'd0);
        checkOutput("t6_rst_done", 32'(req_done), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_err", 32'(timeout_err), 32'd0);
        req = '0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        eng_lat = 2;
        req = 4'b1010;
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t6_grant_after_rst", 32'(g), 32'd1);
        runOp(1'b0, g, s, d, b, dv);
        checkOutput("t6_second_grant", 32'(g), 32'd3);

        // Random traffic, stray done pulses, clears and occasional resets.
        doReset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = req | N'($urandom);
            eng_lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 9));
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 249) != 0));
        end
        req = '0;
        for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
